core_ifu: RTL and testbench
===========================

// Module: core_ifu
// PURPOSE
//   Instruction fetch unit: owns the PC and issues single-beat reads to instruction memory over a
//   valid/ready read channel. Reports fetch progress to the hazard control unit via HCU_IMEM_BUSY
//   and HCU_IMEM_DONE, and advances only on HCU_PC_WRITE. Accepts redirects (branch, JAL, JALR) at
//   any time. An in-flight fetch that a redirect makes stale is drained and its data dropped.
//   Sits between instruction memory and the IF/ID pipeline register.
// PARAMETERS
//   RESET_VECTOR  32'h0000_0000  PC value after reset
//   NOP_INSTR     32'h0000_0013  IF_INSTR value when no valid instruction (addi x0,x0,0)
// PORTS
//   CLK             in   1   clock, rising edge
//   NRST            in   1   synchronous active-low reset
//   HCU_PC_WRITE    in   1   consumer accepted IF_INSTR; advance PC
//   C_REDIRECT      in   1   redirect request (taken branch / JAL / JALR)
//   C_TARGET        in   32  redirect target PC; bits[1:0] forced to 0
//   IMEM_ARADDR     out  32  read address
//   IMEM_ARVALID    out  1   read address valid
//   IMEM_ARREADY    in   1   read address accepted
//   IMEM_RDATA      in   32  read data
//   IMEM_RRESP      in   2   read response; nonzero = error
//   IMEM_RVALID     in   1   read data valid
//   IMEM_RREADY     out  1   read data ready
//   IF_PC           out  32  PC of IF_INSTR
//   IF_INSTR        out  32  fetched instruction
//   IF_VALID        out  1   IF_INSTR/IF_PC hold a valid fetched instruction
//   IF_FAULT        out  1   held instruction came back with RRESP!=0
//   HCU_IMEM_BUSY   out  1   fetch outstanding (state ADDR or DATA)
//   HCU_IMEM_DONE   out  1   one-cycle pulse, first cycle a valid instruction is presented
// BEHAVIOUR
// - Reset (NRST=0 at CLK edge): state=IDLE; PC=RESET_VECTOR; discard=0; IMEM_ARVALID=0;
//   IMEM_RREADY=0; IF_VALID=0; IF_FAULT=0; IF_INSTR=NOP_INSTR; IF_PC=RESET_VECTOR; BUSY=0; DONE=0.
//   Reset mid-fetch abandons the transaction. The memory side must be reset with the core.
// - IMEM_ARADDR = PC at all times. IMEM_ARVALID=1 iff state==ADDR. IMEM_RREADY=1 iff state==DATA.
// - Registered outputs: IF_*, HCU_IMEM_DONE. HCU_IMEM_BUSY is decoded from state.
// - IDLE: next cycle go to ADDR. No conditions.
// - ADDR: hold ARVALID and ARADDR stable until ARREADY; never withdraw. On ARREADY go to DATA.
// - DATA: on RVALID:
//     * If discard=1, or C_REDIRECT is asserted this cycle: drop data; PC<=target; discard<=0;
//       go to ADDR.
//     * Otherwise: IF_INSTR<=RDATA (NOP_INSTR if RRESP!=0); IF_FAULT<=(RRESP!=0); IF_PC<=PC;
//       IF_VALID<=1; DONE<=1 for one cycle; go to HOLD.
// - HOLD: BUSY=0.
//     * C_REDIRECT (priority): PC<=C_TARGET; IF_VALID<=0; go to ADDR.
//     * Else HCU_PC_WRITE: PC<=PC+4 (mod 2^32 wrap); IF_VALID<=0; go to ADDR.
//     * Else hold all outputs.
// - Redirect in ADDR, or in DATA without RVALID: latch pending target (C_TARGET & ~3); discard<=1.
//   A later redirect before drain overwrites the pending target; the latest redirect wins.
//   In ADDR, ARADDR stays at the old PC until that handshake completes.
// - HCU_PC_WRITE is ignored outside HOLD.
// - Latency: with zero-wait memory (ARREADY=1, RVALID the cycle after AR handshake),
//   ADDR->DATA->HOLD takes 2 cycles. Back-to-back throughput is one instruction per 3 cycles.
// TESTING
// 1 Release reset, ARREADY=1, RVALID=1 one cycle later with RDATA=32'h00500093
//   -> ARADDR=0; IF_INSTR=32'h00500093, IF_PC=0, IF_VALID=1; DONE high exactly 1 cycle.
// 2 In HOLD, pulse HCU_PC_WRITE -> IF_VALID drops; next ARADDR=4; BUSY high until next RVALID.
// 3 C_REDIRECT with C_TARGET=32'h103 during DATA, RVALID 3 cycles later
//   -> data dropped, DONE stays 0; next ARADDR=32'h100; second fetch presented with IF_PC=32'h100.
// 4 Two redirects during ADDR (targets 0x40 then 0x80), ARREADY delayed 4 cycles
//   -> ARADDR stable at old PC until handshake; first read dropped; next ARADDR=32'h80.
// 5 RRESP=2'b10 on RVALID -> IF_FAULT=1, IF_INSTR=32'h00000013, IF_VALID=1.
// 6 NRST low mid-DATA -> next cycle all outputs at reset values; after release ARADDR=RESET_VECTOR.

Source files
------------

// File: rtl/core_ifu.sv
// Instruction fetch unit: owns the PC, issues single-beat reads over a valid/ready channel,
// presents fetched instructions to IF/ID and drains fetches made stale by a redirect.
module core_ifu #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        HCU_PC_WRITE,
  input  logic        C_REDIRECT,
  input  logic [31:0] C_TARGET,
  output logic [31:0] IMEM_ARADDR,
  output logic        IMEM_ARVALID,
  input  logic        IMEM_ARREADY,
  input  logic [31:0] IMEM_RDATA,
  input  logic [1:0]  IMEM_RRESP,
  input  logic        IMEM_RVALID,
  output logic        IMEM_RREADY,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTR,
  output logic        IF_VALID,
  output logic        IF_FAULT,
  output logic        HCU_IMEM_BUSY,
  output logic        HCU_IMEM_DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_r, state_n;
  logic [31:0] pc_r, pc_n;
  logic [31:0] pend_r, pend_n;
  logic        discard_r, discard_n;
  logic [31:0] if_pc_r, if_pc_n;
  logic [31:0] if_instr_r, if_instr_n;
  logic        if_valid_r, if_valid_n;
  logic        if_fault_r, if_fault_n;
  logic        done_r, done_n;
  logic [31:0] tgt_s;

  assign tgt_s = {C_TARGET[31:2], 2'b00};

  // Next-state and next-register decode for the fetch FSM
  always_comb begin
    state_n    = state_r;
    pc_n       = pc_r;
    pend_n     = pend_r;
    discard_n  = discard_r;
    if_pc_n    = if_pc_r;
    if_instr_n = if_instr_r;
    if_valid_n = if_valid_r;
    if_fault_n = if_fault_r;
    done_n     = 1'b0;
    case (state_r)
      IDLE: begin
        state_n = ADDR;
        if (C_REDIRECT) begin
          pc_n = tgt_s;
        end else begin
          pc_n = pc_r;
        end
      end
      ADDR: begin
        // ARADDR must stay at the old PC until the handshake, so redirects only park here
        if (C_REDIRECT) begin
          pend_n    = tgt_s;
          discard_n = 1'b1;
        end else begin
          discard_n = discard_r;
        end
        if (IMEM_ARREADY) begin
          state_n = DATA;
        end else begin
          state_n = ADDR;
        end
      end
      DATA: begin
        if (IMEM_RVALID) begin
          if (discard_r || C_REDIRECT) begin
            pc_n      = C_REDIRECT ? tgt_s : pend_r;
            discard_n = 1'b0;
            state_n   = ADDR;
          end else begin
            if_instr_n = (IMEM_RRESP != 2'b00) ? NOP_INSTR : IMEM_RDATA;
            if_fault_n = (IMEM_RRESP != 2'b00);
            if_pc_n    = pc_r;
            if_valid_n = 1'b1;
            done_n     = 1'b1;
            state_n    = HOLD;
          end
        end else if (C_REDIRECT) begin
          pend_n    = tgt_s;
          discard_n = 1'b1;
        end else begin
          state_n = DATA;
        end
      end
      HOLD: begin
        if (C_REDIRECT) begin
          pc_n       = tgt_s;
          if_valid_n = 1'b0;
          state_n    = ADDR;
        end else if (HCU_PC_WRITE) begin
          pc_n       = pc_r + 32'd4;
          if_valid_n = 1'b0;
          state_n    = ADDR;
        end else begin
          state_n = HOLD;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_r    <= IDLE;
      pc_r       <= RESET_VECTOR;
      pend_r     <= RESET_VECTOR;
      discard_r  <= 1'b0;
      if_pc_r    <= RESET_VECTOR;
      if_instr_r <= NOP_INSTR;
      if_valid_r <= 1'b0;
      if_fault_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      pc_r       <= pc_n;
      pend_r     <= pend_n;
      discard_r  <= discard_n;
      if_pc_r    <= if_pc_n;
      if_instr_r <= if_instr_n;
      if_valid_r <= if_valid_n;
      if_fault_r <= if_fault_n;
      done_r     <= done_n;
    end
  end

  assign IMEM_ARADDR   = pc_r;
  assign IMEM_ARVALID  = (state_r == ADDR);
  assign IMEM_RREADY   = (state_r == DATA);
  assign HCU_IMEM_BUSY = (state_r == ADDR) || (state_r == DATA);
  assign HCU_IMEM_DONE = done_r;
  assign IF_PC         = if_pc_r;
  assign IF_INSTR      = if_instr_r;
  assign IF_VALID      = if_valid_r;
  assign IF_FAULT      = if_fault_r;

endmodule

// File: tb/tb_core_ifu.sv
// Directed, table-driven bench for core_ifu: one row per clock with hand-computed expectations,
// followed by a short hand-written fetch/hold sequence.
module tb_core_ifu;

  logic        CLK = 1'b0;
  logic        NRST, HCU_PC_WRITE, C_REDIRECT, IMEM_ARREADY, IMEM_RVALID;
  logic [31:0] C_TARGET, IMEM_RDATA;
  logic [1:0]  IMEM_RRESP;
  logic [31:0] IMEM_ARADDR, IF_PC, IF_INSTR;
  logic        IMEM_ARVALID, IMEM_RREADY, IF_VALID, IF_FAULT, HCU_IMEM_BUSY, HCU_IMEM_DONE;

  int tests = 0;
  int fails = 0;

  core_ifu dut (
    .CLK(CLK), .NRST(NRST), .HCU_PC_WRITE(HCU_PC_WRITE), .C_REDIRECT(C_REDIRECT),
    .C_TARGET(C_TARGET), .IMEM_ARADDR(IMEM_ARADDR), .IMEM_ARVALID(IMEM_ARVALID),
    .IMEM_ARREADY(IMEM_ARREADY), .IMEM_RDATA(IMEM_RDATA), .IMEM_RRESP(IMEM_RRESP),
    .IMEM_RVALID(IMEM_RVALID), .IMEM_RREADY(IMEM_RREADY), .IF_PC(IF_PC), .IF_INSTR(IF_INSTR),
    .IF_VALID(IF_VALID), .IF_FAULT(IF_FAULT), .HCU_IMEM_BUSY(HCU_IMEM_BUSY),
    .HCU_IMEM_DONE(HCU_IMEM_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        nrst, pcw, redir, arready, rvalid;
    logic [31:0] target, rdata;
    logic [1:0]  rresp;
    logic [31:0] araddr;
    logic        arvalid, rready, busy;
    logic [31:0] if_pc, if_instr;
    logic        if_valid, if_fault, done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic nrst, pcw, redir, input logic [31:0] target,
                     input logic arready, rvalid, input logic [1:0] rresp,
                     input logic [31:0] rdata, araddr, input logic arvalid, rready, busy,
                     input logic [31:0] if_pc, if_instr, input logic if_valid, if_fault, done);
    vec_t v;
    v.nrst = nrst; v.pcw = pcw; v.redir = redir; v.target = target;
    v.arready = arready; v.rvalid = rvalid; v.rresp = rresp; v.rdata = rdata;
    v.araddr = araddr; v.arvalid = arvalid; v.rready = rready; v.busy = busy;
    v.if_pc = if_pc; v.if_instr = if_instr; v.if_valid = if_valid; v.if_fault = if_fault;
    v.done = done;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic nrst, pcw, redir, input logic [31:0] target,
                       input logic arready, rvalid, input logic [1:0] rresp,
                       input logic [31:0] rdata);
    NRST = nrst; HCU_PC_WRITE = pcw; C_REDIRECT = redir; C_TARGET = target;
    IMEM_ARREADY = arready; IMEM_RVALID = rvalid; IMEM_RRESP = rresp; IMEM_RDATA = rdata;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_out();
    return {IMEM_ARADDR, IF_PC, IF_INSTR, 25'd0, IMEM_ARVALID, IMEM_RREADY, HCU_IMEM_BUSY,
            IF_VALID, IF_FAULT, HCU_IMEM_DONE, 1'b0};
  endfunction

  initial begin
    int done_cnt;
    int waited;
    logic [127:0] exp;
    //   nrst pcw rdr target        ar rv rsp rdata           araddr        av rr bz if_pc         if_instr      v  f  d
    add(0, 0, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h13,       0, 0, 0);
    add(0, 0, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h13,       0, 0, 0);
    add(1, 0, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h0,        1, 0, 1, 32'h0,        32'h13,       0, 0, 0);
    add(1, 0, 0, 32'h0,          1, 0, 2'd0, 32'h0,        32'h0,        0, 1, 1, 32'h0,        32'h13,       0, 0, 0);
    add(1, 0, 0, 32'h0,          0, 1, 2'd0, 32'h00500093, 32'h0,        0, 0, 0, 32'h0,        32'h00500093, 1, 0, 1);
    add(1, 0, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h00500093, 1, 0, 0);
    add(1, 1, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h4,        1, 0, 1, 32'h0,        32'h00500093, 0, 0, 0);
    add(1, 0, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h4,        1, 0, 1, 32'h0,        32'h00500093, 0, 0, 0);
    add(1, 0, 0, 32'h0,          1, 0, 2'd0, 32'h0,        32'h4,        0, 1, 1, 32'h0,        32'h00500093, 0, 0, 0);
    add(1, 0, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h4,        0, 1, 1, 32'h0,        32'h00500093, 0, 0, 0);
    add(1, 0, 0, 32'h0,          0, 1, 2'd2, 32'hDEADBEEF, 32'h4,        0, 0, 0, 32'h4,        32'h13,       1, 1, 1);
    add(1, 0, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h4,        0, 0, 0, 32'h4,        32'h13,       1, 1, 0);
    // stale fetch: redirect in DATA, data returns three cycles later
    add(1, 1, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h8,        1, 0, 1, 32'h4,        32'h13,       0, 1, 0);
    add(1, 0, 0, 32'h0,          1, 0, 2'd0, 32'h0,        32'h8,        0, 1, 1, 32'h4,        32'h13,       0, 1, 0);
    add(1, 0, 1, 32'h103,        0, 0, 2'd0, 32'h0,        32'h8,        0, 1, 1, 32'h4,        32'h13,       0, 1, 0);
    add(1, 0, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h8,        0, 1, 1, 32'h4,        32'h13,       0, 1, 0);
    add(1, 0, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h8,        0, 1, 1, 32'h4,        32'h13,       0, 1, 0);
    add(1, 0, 0, 32'h0,          0, 1, 2'd0, 32'h11111111, 32'h100,      1, 0, 1, 32'h4,        32'h13,       0, 1, 0);
    add(1, 0, 0, 32'h0,          1, 0, 2'd0, 32'h0,        32'h100,      0, 1, 1, 32'h4,        32'h13,       0, 1, 0);
    add(1, 0, 0, 32'h0,          0, 1, 2'd0, 32'h22222222, 32'h100,      0, 0, 0, 32'h100,      32'h22222222, 1, 0, 1);
    // two redirects in ADDR with a slow address handshake
    add(1, 1, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h104,      1, 0, 1, 32'h100,      32'h22222222, 0, 0, 0);
    add(1, 0, 1, 32'h40,         0, 0, 2'd0, 32'h0,        32'h104,      1, 0, 1, 32'h100,      32'h22222222, 0, 0, 0);
    add(1, 0, 1, 32'h80,         0, 0, 2'd0, 32'h0,        32'h104,      1, 0, 1, 32'h100,      32'h22222222, 0, 0, 0);
    add(1, 0, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h104,      1, 0, 1, 32'h100,      32'h22222222, 0, 0, 0);
    add(1, 0, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h104,      1, 0, 1, 32'h100,      32'h22222222, 0, 0, 0);
    add(1, 0, 0, 32'h0,          1, 0, 2'd0, 32'h0,        32'h104,      0, 1, 1, 32'h100,      32'h22222222, 0, 0, 0);
    add(1, 0, 0, 32'h0,          0, 1, 2'd0, 32'h33333333, 32'h80,       1, 0, 1, 32'h100,      32'h22222222, 0, 0, 0);
    add(1, 0, 0, 32'h0,          1, 0, 2'd0, 32'h0,        32'h80,       0, 1, 1, 32'h100,      32'h22222222, 0, 0, 0);
    add(1, 0, 0, 32'h0,          0, 1, 2'd0, 32'h44444444, 32'h80,       0, 0, 0, 32'h80,       32'h44444444, 1, 0, 1);
    // redirect beats PC write in HOLD; then reset mid-DATA
    add(1, 1, 1, 32'h203,        0, 0, 2'd0, 32'h0,        32'h200,      1, 0, 1, 32'h80,       32'h44444444, 0, 0, 0);
    add(1, 0, 0, 32'h0,          1, 0, 2'd0, 32'h0,        32'h200,      0, 1, 1, 32'h80,       32'h44444444, 0, 0, 0);
    add(0, 0, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h0,        0, 0, 0, 32'h0,        32'h13,       0, 0, 0);
    add(1, 0, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h0,        1, 0, 1, 32'h0,        32'h13,       0, 0, 0);
    add(1, 0, 0, 32'h0,          1, 0, 2'd0, 32'h0,        32'h0,        0, 1, 1, 32'h0,        32'h13,       0, 0, 0);
    add(1, 0, 0, 32'h0,          0, 1, 2'd0, 32'h55,       32'h0,        0, 0, 0, 32'h0,        32'h55,       1, 0, 1);
    // PC wrap and redirect coinciding with RVALID
    add(1, 0, 1, 32'hFFFFFFFF,   0, 0, 2'd0, 32'h0,        32'hFFFFFFFC, 1, 0, 1, 32'h0,        32'h55,       0, 0, 0);
    add(1, 0, 0, 32'h0,          1, 0, 2'd0, 32'h0,        32'hFFFFFFFC, 0, 1, 1, 32'h0,        32'h55,       0, 0, 0);
    add(1, 0, 0, 32'h0,          0, 1, 2'd0, 32'h66,       32'hFFFFFFFC, 0, 0, 0, 32'hFFFFFFFC, 32'h66,       1, 0, 1);
    add(1, 1, 0, 32'h0,          0, 0, 2'd0, 32'h0,        32'h0,        1, 0, 1, 32'hFFFFFFFC, 32'h66,       0, 0, 0);
    add(1, 0, 0, 32'h0,          1, 0, 2'd0, 32'h0,        32'h0,        0, 1, 1, 32'hFFFFFFFC, 32'h66,       0, 0, 0);
    add(1, 0, 1, 32'h300,        0, 1, 2'd0, 32'h77,       32'h300,      1, 0, 1, 32'hFFFFFFFC, 32'h66,       0, 0, 0);

    drive(0, 0, 0, 32'h0, 0, 0, 2'd0, 32'h0);
    @(negedge CLK);
    foreach (vecs[i]) begin
      drive(vecs[i].nrst, vecs[i].pcw, vecs[i].redir, vecs[i].target,
            vecs[i].arready, vecs[i].rvalid, vecs[i].rresp, vecs[i].rdata);
      @(posedge CLK);
      #1;
      exp = {vecs[i].araddr, vecs[i].if_pc, vecs[i].if_instr, 25'd0, vecs[i].arvalid,
             vecs[i].rready, vecs[i].busy, vecs[i].if_valid, vecs[i].if_fault, vecs[i].done, 1'b0};
      check($sformatf("row%0d", i), pack_out(), exp);
    end

    // Hand sequence: fetch at 0x300 with a bounded wait for RREADY, then DONE must pulse once
    drive(1, 0, 0, 32'h0, 1, 0, 2'd0, 32'h0);
    waited = 0;
    while (!IMEM_RREADY && waited < 10) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    check("rready_wait", {127'd0, IMEM_RREADY}, 128'd1);
    drive(1, 0, 0, 32'h0, 0, 1, 2'd0, 32'h88);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK);
      #1;
      drive(1, 0, 0, 32'h0, 0, 0, 2'd0, 32'h0);
      if (HCU_IMEM_DONE) done_cnt++;
    end
    check("done_pulses", 128'(done_cnt), 128'd1);
    check("hold_fetch", {IF_PC, IF_INSTR, 63'd0, IF_VALID},
          {32'h300, 32'h88, 63'd0, 1'b1});
    check("hold_idle_bus", {125'd0, IMEM_ARVALID, IMEM_RREADY, HCU_IMEM_BUSY}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
